// File: rtl/relu_maxpool2x2_pkg.sv
// Shared constants for the ReLU + 2x2 max-pool stage and the convolution stage feeding it.
package relu_maxpool2x2_pkg;

    localparam int DW_IN_DEF  = 16;
    localparam int DW_OUT_DEF = 8;
    localparam int ROW_W_DEF  = 480;
    localparam int SHIFT_DEF  = 4;
    localparam int LB_DEPTH   = ROW_W_DEF / 2;
    localparam int NUM_CH     = 2;

    typedef enum logic {
        ROW_EVEN = 1'b0,
        ROW_ODD  = 1'b1
    } row_par_e;

    // Index width that never collapses to zero bits for tiny depths.
    function automatic int clog2_min1(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/relu_maxpool2x2_pool_channel.sv
// One channel: ReLU/requantise register, row/column tracking, pair register,
// half-row line buffer and the 2x2 max output register.
module pool_channel
    import relu_maxpool2x2_pkg::*;
#(
    parameter int DW_IN  = DW_IN_DEF,
    parameter int DW_OUT = DW_OUT_DEF,
    parameter int ROW_W  = ROW_W_DEF,
    parameter int SHIFT  = SHIFT_DEF
) (
    input  logic              clk,
    input  logic              Rst_n,
    input  logic [DW_IN-1:0]  din_i,
    input  logic              valid_i,
    output logic [DW_OUT-1:0] dout_o,
    output logic              valid_o
);

    localparam int DEPTH = ROW_W / 2;
    localparam int CW    = clog2_min1(ROW_W);
    localparam int AW    = clog2_min1(DEPTH);
    localparam logic [DW_IN-1:0] SAT = DW_IN'({DW_OUT{1'b1}});

    logic [DW_IN-1:0]  shifted;
    logic [DW_OUT-1:0] quant;

    always_comb begin
        shifted = din_i >> SHIFT;
        if (din_i[DW_IN-1])
            quant = '0;
        else if (shifted > SAT)
            quant = '1;
        else
            quant = shifted[DW_OUT-1:0];
    end

    // Position of the pixel currently on the input.
    logic [CW-1:0] col_q, col_d;
    row_par_e      row_q, row_d;

    always_comb begin
        col_d = col_q;
        row_d = row_q;
        if (valid_i) begin
            if (col_q == CW'(ROW_W - 1)) begin
                col_d = '0;
                row_d = row_par_e'(~row_q);
            end else begin
                col_d = col_q + 1'b1;
            end
        end
    end

    logic              vld1_q;
    logic [DW_OUT-1:0] q_q;
    logic              odd_col_q;
    row_par_e          odd_row_q;
    logic [AW-1:0]     idx_q;

    always_ff @(posedge clk) begin
        if (!Rst_n) begin
            vld1_q    <= 1'b0;
            q_q       <= '0;
            odd_col_q <= 1'b0;
            odd_row_q <= ROW_EVEN;
            idx_q     <= '0;
            col_q     <= '0;
            row_q     <= ROW_EVEN;
        end else begin
            vld1_q <= valid_i;
            if (valid_i) begin
                q_q       <= quant;
                odd_col_q <= col_q[0];
                odd_row_q <= row_q;
                idx_q     <= AW'(col_q >> 1);
            end
            col_q <= col_d;
            row_q <= row_d;
        end
    end

    logic [DW_OUT-1:0] mem [DEPTH];
    logic [DW_OUT-1:0] rd_q;
    logic [DW_OUT-1:0] pair_q;
    logic [DW_OUT-1:0] m2, m3;
    logic              wr_en, rd_en;

    assign m2    = (q_q > pair_q) ? q_q : pair_q;
    assign m3    = (rd_q > m2) ? rd_q : m2;
    assign wr_en = Rst_n && vld1_q && odd_col_q && (odd_row_q == ROW_EVEN);
    // Read is launched as the odd-row odd-column pixel arrives, so the entry
    // was written by the even row at least one pixel earlier.
    assign rd_en = valid_i && col_q[0] && (row_q == ROW_ODD);

    always_ff @(posedge clk) begin
        if (wr_en)
            mem[idx_q] <= m2;
        if (rd_en)
            rd_q <= mem[AW'(col_q >> 1)];
    end

    logic [DW_OUT-1:0] dout_q;
    logic              vout_q;

    always_ff @(posedge clk) begin
        if (!Rst_n) begin
            pair_q <= '0;
            dout_q <= '0;
            vout_q <= 1'b0;
        end else begin
            vout_q <= 1'b0;
            if (vld1_q) begin
                if (!odd_col_q) begin
                    pair_q <= q_q;
                end else if (odd_row_q == ROW_ODD) begin
                    dout_q <= m3;
                    vout_q <= 1'b1;
                end
            end
        end
    end

    assign dout_o  = dout_q;
    assign valid_o = vout_q;

endmodule

// File: rtl/relu_maxpool2x2.sv
// Two independent ReLU + requantise + 2x2 max-pool channels.
module relu_maxpool2x2
    import relu_maxpool2x2_pkg::*;
#(
    parameter int DW_IN  = DW_IN_DEF,
    parameter int DW_OUT = DW_OUT_DEF,
    parameter int ROW_W  = ROW_W_DEF,
    parameter int SHIFT  = SHIFT_DEF
) (
    input  logic              clk,
    input  logic              Rst_n,
    input  logic [DW_IN-1:0]  din1,
    input  logic              valid_in1,
    input  logic [DW_IN-1:0]  din2,
    input  logic              valid_in2,
    output logic [DW_OUT-1:0] dout1,
    output logic              valid_out1,
    output logic [DW_OUT-1:0] dout2,
    output logic              valid_out2
);

    if ((ROW_W % 2) != 0 || ROW_W < 2) begin : g_row_w_chk
        $error("relu_maxpool2x2: ROW_W must be even and at least 2");
    end

    logic [NUM_CH-1:0][DW_IN-1:0]  din_a;
    logic [NUM_CH-1:0]             vin_a;
    logic [NUM_CH-1:0][DW_OUT-1:0] dout_a;
    logic [NUM_CH-1:0]             vout_a;

    assign din_a = {din2, din1};
    assign vin_a = {valid_in2, valid_in1};

    for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
        pool_channel #(
            .DW_IN (DW_IN),
            .DW_OUT(DW_OUT),
            .ROW_W (ROW_W),
            .SHIFT (SHIFT)
        ) u_ch (
            .clk    (clk),
            .Rst_n  (Rst_n),
            .din_i  (din_a[g]),
            .valid_i(vin_a[g]),
            .dout_o (dout_a[g]),
            .valid_o(vout_a[g])
        );
    end

    assign dout1      = dout_a[0];
    assign valid_out1 = vout_a[0];
    assign dout2      = dout_a[1];
    assign valid_out2 = vout_a[1];

endmodule
